// File: rtl/tdm_seq_pkg.sv
// Shared constants and state encoding for the TDM channel sequencer.
package tdm_seq_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DWELL = 2'd2,
    GUARD = 2'd3
  } state_e;
endpackage

// File: rtl/tdm_next_chan_finder.sv
// Combinational search for the lowest enabled channel at or above a pointer.
module tdm_next_chan_finder
  import tdm_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W:0]    ptr_i,
  output logic [SEL_W-1:0]  idx_o,
  output logic              found_o
);
  localparam int PW = SEL_W + 1;

  // Pointer is one bit wider so that "past the last channel" finds nothing.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (PW'(i) >= ptr_i)) begin
        idx_o   = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tdm_channel_sequencer.sv
// TDM scheduler feeding a 1-to-8 demux: per-channel dwell window, fixed guard
// of zeros, frame counting, single-shot or continuous scanning.
//
// state | meaning
// IDLE  | waiting for start; config table writable
// SCAN  | one cycle: pick next enabled channel, load dwell counter
// DWELL | source sample routed to sel_o for dwell+1 cycles
// GUARD | GUARD_CYCLES of zero output, sel_o held
module tdm_channel_sequencer
  import tdm_seq_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int GUARD_CYCLES = 2,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_we_i,
  input  logic [SEL_W-1:0]       cfg_chan_i,
  input  logic [DWELL_W-1:0]     cfg_dwell_i,
  input  logic                   cfg_en_i,
  output logic                   cfg_ready_o,
  input  logic                   start_i,
  input  logic                   continuous_i,
  input  logic                   stop_i,
  input  logic                   src_data_i,
  output logic                   data_o,
  output logic [SEL_W-1:0]       sel_o,
  output logic                   chan_active_o,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic                   start_err_o
);
  localparam int PW = SEL_W + 1;
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [SEL_W:0]         ptr_q, ptr_d;
  logic [DWELL_W-1:0]     dwell_cnt_q, dwell_cnt_d;
  logic [GW-1:0]          guard_cnt_q, guard_cnt_d;
  logic                   stop_q, stop_d;
  logic                   frame_done_q, frame_done_d;
  logic                   start_err_q, start_err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [NUM_CH-1:0]      en_q, en_d;
  logic [DWELL_W-1:0]     dwell_tab_q [NUM_CH];
  logic [DWELL_W-1:0]     dwell_tab_d [NUM_CH];

  logic [SEL_W-1:0]       scan_idx, next_idx;
  logic                   scan_found, next_found;
  logic                   chan_end;

  tdm_next_chan_finder u_scan_find (
    .mask_i  (en_q),
    .ptr_i   (ptr_q),
    .idx_o   (scan_idx),
    .found_o (scan_found)
  );

  tdm_next_chan_finder u_next_find (
    .mask_i  (en_q),
    .ptr_i   ({1'b0, sel_q} + PW'(1)),
    .idx_o   (next_idx),
    .found_o (next_found)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    dwell_cnt_d  = dwell_cnt_q;
    guard_cnt_d  = guard_cnt_q;
    stop_d       = stop_q;
    frame_done_d = 1'b0;
    start_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    en_d         = en_q;
    dwell_tab_d  = dwell_tab_q;
    chan_end     = 1'b0;

    if ((state_q != IDLE) && stop_i) stop_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (cfg_we_i) begin
          en_d[cfg_chan_i]        = cfg_en_i;
          dwell_tab_d[cfg_chan_i] = cfg_dwell_i;
        end
        if (start_i) begin
          if (|en_q) begin
            state_d = SCAN;
            ptr_d   = '0;
            stop_d  = 1'b0;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (scan_found) begin
          sel_d       = scan_idx;
          dwell_cnt_d = dwell_tab_q[scan_idx];
          state_d     = DWELL;
        end else begin
          state_d = IDLE;
          sel_d   = '0;
        end
      end
      DWELL: begin
        if (dwell_cnt_q == '0) begin
          if (GUARD_CYCLES == 0) begin
            chan_end = 1'b1;
          end else begin
            guard_cnt_d = GW'(GUARD_CYCLES - 1);
            state_d     = GUARD;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      GUARD: begin
        if (guard_cnt_q == '0) chan_end = 1'b1;
        else                   guard_cnt_d = guard_cnt_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase

    // A stop arriving on the deciding cycle itself is honoured too.
    if (chan_end) begin
      if (stop_q || stop_i) begin
        state_d = IDLE;
        sel_d   = '0;
        stop_d  = 1'b0;
      end else if (next_found) begin
        ptr_d   = {1'b0, next_idx};
        state_d = SCAN;
      end else begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
        if (continuous_i) begin
          ptr_d   = '0;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
          sel_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      ptr_q        <= '0;
      dwell_cnt_q  <= '0;
      guard_cnt_q  <= '0;
      stop_q       <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
      en_q         <= '0;
      dwell_tab_q  <= '{default: '0};
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      dwell_cnt_q  <= dwell_cnt_d;
      guard_cnt_q  <= guard_cnt_d;
      stop_q       <= stop_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
      frame_cnt_q  <= frame_cnt_d;
      en_q         <= en_d;
      dwell_tab_q  <= dwell_tab_d;
    end
  end

  assign data_o        = (state_q == DWELL) & src_data_i;
  assign chan_active_o = (state_q == DWELL);
  assign busy_o        = (state_q != IDLE);
  assign cfg_ready_o   = (state_q == IDLE);
  assign sel_o         = sel_q;
  assign frame_done_o  = frame_done_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign start_err_o   = start_err_q;
endmodule

// File: tb/tb_tdm_channel_sequencer.sv
// Bench for tdm_channel_sequencer: a frame model pushes expected per-cycle
// outputs into a queue, which is popped and compared cycle by cycle.
module tb_tdm_channel_sequencer;
  localparam int GUARD = 2;

  logic        clk = 1'b0;
  logic        rst_i, cfg_we_i, cfg_en_i, start_i, continuous_i, stop_i, src_data_i;
  logic [2:0]  cfg_chan_i;
  logic [7:0]  cfg_dwell_i;
  logic        cfg_ready_o, data_o, chan_active_o, busy_o, frame_done_o, start_err_o;
  logic [2:0]  sel_o;
  logic [15:0] frame_cnt_o;

  always #5 clk = ~clk;

  tdm_channel_sequencer #(.DWELL_W(8), .GUARD_CYCLES(GUARD), .FRAME_CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_chan_i(cfg_chan_i),
    .cfg_dwell_i(cfg_dwell_i), .cfg_en_i(cfg_en_i), .cfg_ready_o(cfg_ready_o),
    .start_i(start_i), .continuous_i(continuous_i), .stop_i(stop_i),
    .src_data_i(src_data_i), .data_o(data_o), .sel_o(sel_o),
    .chan_active_o(chan_active_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .frame_cnt_o(frame_cnt_o), .start_err_o(start_err_o)
  );

  typedef struct {
    logic [2:0]  sel;
    logic        active;
    logic        busy;
    logic        fdone;
    logic [15:0] fcnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  m_en;
  logic [7:0]  m_dwell [8];
  logic [2:0]  m_prev;
  logic        m_pend;
  logic [15:0] m_fcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic [2:0] sel, input logic act,
                               input logic busy, input logic fd);
    exp_t e;
    e.sel = sel; e.active = act; e.busy = busy; e.fdone = fd; e.fcnt = m_fcnt;
    sb.push_back(e);
  endfunction

  // One frame of expected cycles; stop_after>0 ends the run after that many channels.
  function automatic void gen_frame(input bit cont, input int stop_after);
    int done_ch = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_en[c]) begin
        push(m_prev, 1'b0, 1'b1, m_pend);
        m_pend = 1'b0;
        for (int d = 0; d <= int'(m_dwell[c]); d++) push(3'(c), 1'b1, 1'b1, 1'b0);
        for (int g = 0; g < GUARD; g++) push(3'(c), 1'b0, 1'b1, 1'b0);
        m_prev = 3'(c);
        done_ch++;
        if (done_ch == stop_after) begin
          push(3'd0, 1'b0, 1'b0, 1'b0);
          m_prev = 3'd0;
          return;
        end
      end
    end
    m_fcnt++;
    m_pend = 1'b1;
    if (!cont) begin
      push(3'd0, 1'b0, 1'b0, 1'b1);
      m_pend = 1'b0;
      m_prev = 3'd0;
    end
  endfunction

  task automatic run_queue(input int stop_at, input int wr_at, input int cont_off_at);
    exp_t e;
    int   i = 0;
    while (sb.size() > 0) begin
      tick();
      src_data_i = 1'($urandom_range(0, 1));
      start_i    = 1'b0;
      stop_i     = (i == stop_at);
      cfg_we_i   = (i == wr_at);
      if (i == wr_at) begin
        cfg_chan_i = 3'd1; cfg_dwell_i = 8'd5; cfg_en_i = 1'b1;
      end
      if (i == cont_off_at) continuous_i = 1'b0;
      #1;
      e = sb.pop_front();
      chk("sel", 32'(sel_o), 32'(e.sel));
      chk("data", 32'(data_o), 32'(e.active & src_data_i));
      chk("active", 32'(chan_active_o), 32'(e.active));
      chk("busy", 32'(busy_o), 32'(e.busy));
      chk("cfg_ready", 32'(cfg_ready_o), 32'(!e.busy));
      chk("frame_done", 32'(frame_done_o), 32'(e.fdone));
      chk("frame_cnt", 32'(frame_cnt_o), 32'(e.fcnt));
      chk("start_err", 32'(start_err_o), 32'd0);
      i++;
    end
    stop_i = 1'b0;
    cfg_we_i = 1'b0;
  endtask

  task automatic cfg(input int ch, input int dw, input bit en);
    cfg_chan_i = 3'(ch); cfg_dwell_i = 8'(dw); cfg_en_i = en; cfg_we_i = 1'b1;
    tick();
    cfg_we_i = 1'b0;
    m_en[ch] = en;
    m_dwell[ch] = 8'(dw);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sel"}, 32'(sel_o), 32'd0);
    chk({tag, "_data"}, 32'(data_o), 32'd0);
    chk({tag, "_active"}, 32'(chan_active_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_fdone"}, 32'(frame_done_o), 32'd0);
    chk({tag, "_fcnt"}, 32'(frame_cnt_o), 32'd0);
    chk({tag, "_serr"}, 32'(start_err_o), 32'd0);
    chk({tag, "_ready"}, 32'(cfg_ready_o), 32'd1);
  endtask

  task automatic model_clear();
    m_en = '0; m_prev = '0; m_pend = 1'b0; m_fcnt = '0;
    for (int k = 0; k < 8; k++) m_dwell[k] = '0;
  endtask

  initial begin
    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_en_i = 1'b0; cfg_chan_i = '0; cfg_dwell_i = '0;
    start_i = 1'b0; continuous_i = 1'b0; stop_i = 1'b0; src_data_i = 1'b1;
    model_clear();
    tick();
    tick();
    check_reset("reset");
    rst_i = 1'b0;

    // start with empty mask
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("err_pulse", 32'(start_err_o), 32'd1);
    chk("err_busy", 32'(busy_o), 32'd0);
    chk("err_sel", 32'(sel_o), 32'd0);
    tick();
    chk("err_clear", 32'(start_err_o), 32'd0);

    // single frame, channels 0 and 2
    cfg(0, 3, 1'b1);
    cfg(2, 1, 1'b1);
    continuous_i = 1'b0;
    start_i = 1'b1;
    gen_frame(1'b0, 0);
    run_queue(-1, -1, -1);

    // continuous, channel 7 only with dwell 0
    cfg(0, 0, 1'b0);
    cfg(2, 0, 1'b0);
    cfg(7, 0, 1'b1);
    continuous_i = 1'b1;
    start_i = 1'b1;
    for (int f = 0; f < 3; f++) gen_frame(1'b1, 0);
    gen_frame(1'b0, 0);
    run_queue(-1, -1, 13);

    // stop during channel 0 dwell of a 3-channel frame
    cfg(7, 0, 1'b0);
    cfg(0, 2, 1'b1);
    cfg(1, 2, 1'b1);
    cfg(2, 2, 1'b1);
    continuous_i = 1'b0;
    start_i = 1'b1;
    gen_frame(1'b0, 1);
    run_queue(2, -1, -1);

    // config write while busy is ignored
    start_i = 1'b1;
    gen_frame(1'b0, 0);
    run_queue(-1, 3, -1);
    start_i = 1'b1;
    gen_frame(1'b0, 0);
    run_queue(-1, -1, -1);

    // same write in idle takes effect
    cfg(1, 5, 1'b1);
    start_i = 1'b1;
    gen_frame(1'b0, 0);
    run_queue(-1, -1, -1);

    // reset during guard clears everything including the table
    cfg(0, 0, 1'b0);
    cfg(1, 0, 1'b0);
    cfg(2, 0, 1'b0);
    cfg(3, 0, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("g_dwell_active", 32'(chan_active_o), 32'd1);
    chk("g_dwell_sel", 32'(sel_o), 32'd3);
    tick();
    chk("g_guard_active", 32'(chan_active_o), 32'd0);
    chk("g_guard_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_clear();
    check_reset("midrst");
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("post_rst_err", 32'(start_err_o), 32'd1);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
